ship_sprite_draw: RTL and testbench

Pixel-pipeline stage directly downstream of the ship sprite ROM. It takes the current raster coordinate and the ship's top-left position, drives the ROM row address, and selects the column bit to produce a registered `is_ship` pixel flag for the colour mapper. It also owns the hit-blink state machine: after a hit the ship flashes for a fixed number of frames and is immune to further hits.

---
 rtl/ship_pkg.sv | 19 +
 rtl/frame_edge_detect.sv | 21 ++
 rtl/ship_sprite_draw.sv | 142 ++++++++++++++
 tb/tb_ship_sprite_draw.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ship_pkg.sv
// Shared types and constants for the ship sprite path (draw stage and bullet logic).
package ship_pkg;

    typedef enum logic {
        ALIVE = 1'b0,
        BLINK = 1'b1
    } ship_state_t;

    localparam int SHIP_W_DEF = 16;
    localparam int SHIP_H_DEF = 8;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    // Width needed to hold 0..v-1, never less than one bit.
    function automatic int cnt_width(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Single-register rising-edge detector for the vsync-rate frame strobe.
module frame_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_strobe,
    output logic o_edge
);

    logic r_strobe_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_strobe_q <= 1'b0;
        end else begin
            r_strobe_q <= i_strobe;
        end
    end

    assign o_edge = i_strobe & ~r_strobe_q;

endmodule

// File: rtl/ship_sprite_draw.sv
// Ship sprite pixel stage: box test, ROM row address, column select, hit-blink FSM.
// Blink FSM is compiled in only when SHIP_BLINK_EN is defined.
//
// state | meaning
// ALIVE | ship fully visible, accepts hits
// BLINK | ship flashing for BLINK_FRAMES frames, hits ignored
module ship_sprite_draw
    import ship_pkg::*;
#(
    parameter int SHIP_W       = SHIP_W_DEF,
    parameter int SHIP_H       = SHIP_H_DEF,
    parameter int SCALE_SHIFT  = 1,
    parameter int BLINK_FRAMES = 64,
    parameter int BLINK_LOG2   = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  ShipX,
    input  logic [9:0]  ShipY,
    input  logic        hit,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        is_ship,
    output logic        blinking
);

    localparam int COL_W = cnt_width(SHIP_W);
    localparam int ROW_W = cnt_width(SHIP_H);
    localparam logic [10:0] BOX_W = 11'(SHIP_W << SCALE_SHIFT);
    localparam logic [10:0] BOX_H = 11'(SHIP_H << SCALE_SHIFT);

    logic [10:0]      w_rel_x;
    logic [10:0]      w_rel_y;
    logic             w_in_box;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_bit_idx;
    logic             w_visible;

    logic [7:0]       r_rom_addr;
    logic [COL_W-1:0] r_col_d;
    logic             r_in_box_d;
    logic             r_is_ship;

    // Widen before subtracting so a ship left/above the raster never wraps into the box.
    assign w_rel_x = {1'b0, DrawX} - {1'b0, ShipX};
    assign w_rel_y = {1'b0, DrawY} - {1'b0, ShipY};

    assign w_in_box = (DrawX >= ShipX) && (w_rel_x < BOX_W) &&
                      (DrawY >= ShipY) && (w_rel_y < BOX_H) &&
                      (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));

    assign w_col = w_rel_x[SCALE_SHIFT +: COL_W];
    assign w_row = w_rel_y[SCALE_SHIFT +: ROW_W];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rom_addr <= 8'd0;
            r_col_d    <= '0;
            r_in_box_d <= 1'b0;
        end else begin
            r_rom_addr <= 8'(w_row);
            r_col_d    <= w_col;
            r_in_box_d <= w_in_box;
        end
    end

    // ROM word MSB is the leftmost pixel.
    assign w_bit_idx = COL_W'(SHIP_W - 1) - r_col_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_is_ship <= 1'b0;
        end else begin
            r_is_ship <= r_in_box_d & rom_data[w_bit_idx] & w_visible;
        end
    end

    assign rom_addr = r_rom_addr;
    assign is_ship  = r_is_ship;

`ifdef SHIP_BLINK_EN
    localparam int FCNT_W = (cnt_width(BLINK_FRAMES) > BLINK_LOG2) ?
                            cnt_width(BLINK_FRAMES) : BLINK_LOG2 + 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

    ship_state_t       r_state;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              w_frame_edge;

    frame_edge_detect u_frame_edge (
        .i_clk    (Clk),
        .i_reset  (Reset),
        .i_strobe (frame_clk),
        .o_edge   (w_frame_edge)
    );

    // A frame edge arriving with the hit is swallowed: the count starts at 0 regardless.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ALIVE;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ALIVE: begin
                    if (hit) begin
                        r_state     <= BLINK;
                        r_frame_cnt <= '0;
                    end
                end
                BLINK: begin
                    if (w_frame_edge) begin
                        if (r_frame_cnt == FCNT_LAST) begin
                            r_state     <= ALIVE;
                            r_frame_cnt <= '0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= ALIVE;
                    r_frame_cnt <= '0;
                end
            endcase
        end
    end

    assign w_visible = (r_state == ALIVE) | r_frame_cnt[BLINK_LOG2];
    assign blinking  = (r_state == BLINK);
`else
    logic w_unused;

    assign w_unused  = &{1'b0, hit, frame_clk};
    assign w_visible = 1'b1;
    assign blinking  = 1'b0;
`endif

endmodule

// File: tb/tb_ship_sprite_draw.sv
// Scoreboard bench for ship_sprite_draw: pixel stimulus pushes expectations, a monitor checks them.
module tb_ship_sprite_draw;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  DrawX, DrawY, ShipX, ShipY;
    logic        hit;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        is_ship;
    logic        blinking;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       chk_addr;
        logic [7:0] addr;
        logic       ship;
        logic [31:0] tag;
    } exp_t;

    exp_t addr_q[$];
    exp_t ship_q[$];
    logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;

    ship_sprite_draw dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .ShipX     (ShipX),
        .ShipY     (ShipY),
        .hit       (hit),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .is_ship   (is_ship),
        .blinking  (blinking)
    );

    always #5 Clk = ~Clk;

    // Ship ROM image: rows 0,1,6,7 outline; rows 2-5 centre block.
    always_comb begin
        case (rom_addr)
            8'd0, 8'd1, 8'd6, 8'd7: rom_data = 16'b0111111111111110;
            8'd2, 8'd3, 8'd4, 8'd5: rom_data = 16'b0000001111000000;
            default:                rom_data = 16'h0000;
        endcase
    end

    always @(posedge Clk) begin
        v1 <= v0;
        v2 <= v1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: rom_addr is due one cycle after the pixel, is_ship two cycles after.
    always @(negedge Clk) begin
        exp_t e;
        if (v1) begin
            if (addr_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL addr_underflow: got empty queue expected entry");
            end else begin
                e = addr_q.pop_front();
                if (e.chk_addr) begin
                    checks++;
                    if (rom_addr !== e.addr) begin
                        failures++;
                        $display("FAIL rom_addr tag=%0d: got %0d expected %0d", e.tag, rom_addr, e.addr);
                    end
                end
            end
        end
        if (v2) begin
            if (ship_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ship_underflow: got empty queue expected entry");
            end else begin
                e = ship_q.pop_front();
                checks++;
                if (is_ship !== e.ship) begin
                    failures++;
                    $display("FAIL is_ship tag=%0d: got %0b expected %0b", e.tag, is_ship, e.ship);
                end
            end
        end
    end

    task automatic px(input int x, input int y, input logic exp_ship,
                      input logic chk_a, input logic [7:0] exp_a, input int tag);
        exp_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        e.chk_addr = chk_a;
        e.addr     = exp_a;
        e.ship     = exp_ship;
        e.tag      = 32'(tag);
        addr_q.push_back(e);
        ship_q.push_back(e);
        v0 = 1'b1;
        @(negedge Clk);
        v0 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((addr_q.size() != 0 || ship_q.size() != 0) && n < 20) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        if (addr_q.size() != 0 || ship_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", addr_q.size() + ship_q.size());
        end
    endtask

    task automatic pulse_frame();
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; hit = 1'b0;
        DrawX = 10'd302; DrawY = 10'd400; ShipX = 10'd300; ShipY = 10'd400;
        repeat (3) @(negedge Clk);
        chk("reset_is_ship", 32'(is_ship), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_blinking", 32'(blinking), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Directed pixels against ship at (300,400).
        px(300, 400, 1'b0, 1'b1, 8'd0, 1);
        px(302, 400, 1'b1, 1'b1, 8'd0, 2);
        px(310, 404, 1'b0, 1'b1, 8'd2, 3);
        px(312, 404, 1'b1, 1'b1, 8'd2, 4);
        px(332, 400, 1'b0, 1'b0, 8'd0, 5);
        px(299, 400, 1'b0, 1'b0, 8'd0, 6);
        px(329, 415, 1'b1, 1'b1, 8'd7, 7);
        px(331, 415, 1'b0, 1'b1, 8'd7, 8);
        px(302, 416, 1'b0, 1'b0, 8'd0, 9);
        px(302, 399, 1'b0, 1'b0, 8'd0, 10);
        px(318, 410, 1'b1, 1'b1, 8'd5, 11);
        drain();

        // Right-edge box: lit only from col 1 (x=622) to the raster edge, no wrap at x<20.
        ShipX = 10'd620;
        for (int x = 0; x < 640; x++) begin
            px(x, 400, (x >= 622), 1'b0, 8'd0, 1000 + x);
        end
        drain();
        ShipX = 10'd300;

`ifdef SHIP_BLINK_EN
        pulse_hit();
        for (int k = 0; k < 64; k++) begin
            px(302, 400, 1'(k >> 3), 1'b0, 8'd0, 2000 + k);
            drain();
            chk("blink_active", 32'(blinking), 32'd1);
            if (k == 10) pulse_hit();
            pulse_frame();
        end
        drain();
        chk("blink_done", 32'(blinking), 32'd0);
        px(302, 400, 1'b1, 1'b0, 8'd0, 2100);
        drain();

        // Hit and frame edge together: the edge is not counted.
        frame_clk = 1'b1; hit = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0; hit = 1'b0;
        @(negedge Clk);
        chk("coincident_blinking", 32'(blinking), 32'd1);
        for (int j = 0; j < 7; j++) pulse_frame();
        px(302, 400, 1'b0, 1'b0, 8'd0, 3007);
        drain();
        pulse_frame();
        px(302, 400, 1'b1, 1'b0, 8'd0, 3008);
        drain();
        for (int j = 8; j < 30; j++) pulse_frame();
        px(302, 400, 1'b1, 1'b0, 8'd0, 3030);
        drain();

        // Reset at frame 30 of the blink.
        DrawX = 10'd302; DrawY = 10'd400;
        Reset = 1'b1;
        @(negedge Clk);
        chk("midblink_reset_blinking", 32'(blinking), 32'd0);
        chk("midblink_reset_is_ship", 32'(is_ship), 32'd0);
        chk("midblink_reset_rom_addr", 32'(rom_addr), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        px(302, 400, 1'b1, 1'b0, 8'd0, 3100);
        drain();
        chk("after_reset_blinking", 32'(blinking), 32'd0);
`else
        pulse_hit();
        chk("noblink_blinking", 32'(blinking), 32'd0);
        pulse_frame();
        px(302, 400, 1'b1, 1'b1, 8'd0, 4000);
        drain();
        chk("noblink_blinking_later", 32'(blinking), 32'd0);
        for (int j = 0; j < 9; j++) pulse_frame();
        px(302, 400, 1'b1, 1'b0, 8'd0, 4001);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
